// File: rtl/addsub_arb_pkg.sv
// addsub_arb_pkg: shared constants for the add/sub arbiter slice.
//   ADDSUB_W   default operand/result width
//   state_e    arbiter FSM states (idle, execute, hold response)
//   REQ0/REQ1  requester identifiers carried on rsp_id
package addsub_arb_pkg;

  localparam int unsigned ADDSUB_W = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StHold = 2'd2
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/addsub_arbiter_if.sv
// addsub_arbiter_if: request/response bundle for addsub_arbiter.
//   req0_*/req1_*  valid/ready request channels carrying a, b and m (0 = add, 1 = sub)
//   rsp_*          valid/ready response channel with id, sum, carry-out and overflow
//   master modport: requesters + response consumer; slave modport: the arbiter
interface addsub_arbiter_if #(
  parameter int unsigned W = 4
);
  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req0_m;

  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         req1_m;

  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [W-1:0] rsp_s;
  logic         rsp_cout;
  logic         rsp_v;

  modport master (
    output req0_valid, req0_a, req0_b, req0_m,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_m,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_s, rsp_cout, rsp_v,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_m,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_m,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_s, rsp_cout, rsp_v,
    input  rsp_ready
  );

endinterface

// File: rtl/addsub_core.sv
// addsub_core: combinational W-bit ripple-carry adder/subtractor.
//   a, b   operands
//   m      0 = a + b, 1 = a - b (b is inverted when m = 1)
//   c_in   carry into bit 0 (tie to m for two's-complement subtraction)
//   s      wrapped result
//   c_out  carry out of the MSB
//   v      signed overflow: carry into MSB xor carry out of MSB
module addsub_core #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         m,
  input  logic         c_in,
  output logic [W-1:0] s,
  output logic         c_out,
  output logic         v
);

  logic [W:0]   w_c;
  logic [W-1:0] w_bx;

  assign w_bx   = b ^ {W{m}};
  assign w_c[0] = c_in;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign s[i]     = a[i] ^ w_bx[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & w_bx[i]) | (w_c[i] & (a[i] ^ w_bx[i]));
  end

  assign c_out = w_c[W];
  assign v     = w_c[W] ^ w_c[W-1];

endmodule

// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin two-requester front end for a shared ripple adder/subtractor.
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    addsub_arbiter_if.slave: two request channels in, one tagged response channel out
// Flow: IDLE -> EXEC (operands latched) -> HOLD (response registered, held until accepted).
// A HOLD cycle that consumes the response may grant the next request in the same cycle.
// Optional build macro ADDSUB_ARB_SAT_EN: saturate rsp_s on signed overflow.
module addsub_arbiter
  import addsub_arb_pkg::*;
#(
  parameter int unsigned W = ADDSUB_W
) (
  input logic             clk,
  input logic             rst_n,
  addsub_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE = StIdle;
  localparam logic [1:0] ST_EXEC = StExec;
  localparam logic [1:0] ST_HOLD = StHold;

  logic [1:0]   r_state;
  logic         r_last_grant;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic         r_m;

  logic         r_rsp_valid;
  logic         r_rsp_id;
  logic [W-1:0] r_rsp_s;
  logic         r_rsp_cout;
  logic         r_rsp_v;

  logic         w_can_accept;
  logic         w_pick1;
  logic         w_accept;
  logic         w_grant_id;
  logic         w_rsp_take;
  logic [W-1:0] w_sum;
  logic         w_cout;
  logic         w_v;
  logic [W-1:0] w_res;

  // Handshake: only from IDLE, or from HOLD when the held response leaves this cycle.
  assign w_rsp_take   = (r_state == ST_HOLD) && bus.rsp_ready;
  assign w_can_accept = (r_state == ST_IDLE) || w_rsp_take;
  // On a tie, requester 1 wins only if requester 0 was granted last.
  assign w_pick1      = bus.req1_valid && (!bus.req0_valid || (r_last_grant == REQ0));
  assign w_accept     = rst_n && w_can_accept && (bus.req0_valid || bus.req1_valid);
  assign w_grant_id   = w_pick1 ? REQ1 : REQ0;

  assign bus.req0_ready = w_accept && !w_pick1;
  assign bus.req1_ready = w_accept && w_pick1;

  addsub_core #(
    .W(W)
  ) u_core (
    .a    (r_a),
    .b    (r_b),
    .m    (r_m),
    .c_in (r_m),
    .s    (w_sum),
    .c_out(w_cout),
    .v    (w_v)
  );

`ifdef ADDSUB_ARB_SAT_EN
  // Clamp toward the sign of A: a signed overflow always has both effective operands of A's sign.
  always_comb begin
    w_res = w_sum;
    if (w_v) begin
      w_res = r_a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end
`else
  assign w_res = w_sum;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_last_grant <= REQ1;
      r_a          <= '0;
      r_b          <= '0;
      r_m          <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= REQ0;
      r_rsp_s      <= '0;
      r_rsp_cout   <= 1'b0;
      r_rsp_v      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_HOLD: begin
          if (w_rsp_take) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
          if (w_accept) begin
            r_state      <= ST_EXEC;
            r_last_grant <= w_grant_id;
            r_a          <= w_pick1 ? bus.req1_a : bus.req0_a;
            r_b          <= w_pick1 ? bus.req1_b : bus.req0_b;
            r_m          <= w_pick1 ? bus.req1_m : bus.req0_m;
          end
        end
        ST_EXEC: begin
          r_state     <= ST_HOLD;
          r_rsp_valid <= 1'b1;
          r_rsp_id    <= r_last_grant;
          r_rsp_s     <= w_res;
          r_rsp_cout  <= w_cout;
          r_rsp_v     <= w_v;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_s     = r_rsp_s;
  assign bus.rsp_cout  = r_rsp_cout;
  assign bus.rsp_v     = r_rsp_v;

endmodule

// File: tb/tb_addsub_arbiter.sv
// tb_addsub_arbiter: directed bench for addsub_arbiter (W = 4).
// Inputs change on the falling edge; outputs are sampled on the falling edge
// (or 1 time unit after driving, for the combinational ready outputs).
module tb_addsub_arbiter;

  logic clk;
  logic rst_n;

  int unsigned n_total;
  int unsigned n_bad;

  addsub_arbiter_if #(.W(4)) bus ();

  addsub_arbiter #(
    .W(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input int id, input logic vld, input logic [3:0] a,
                           input logic [3:0] b, input logic m);
    if (id == 0) begin
      bus.req0_valid = vld; bus.req0_a = a; bus.req0_b = b; bus.req0_m = m;
    end else begin
      bus.req1_valid = vld; bus.req1_a = a; bus.req1_b = b; bus.req1_m = m;
    end
  endtask

  // One isolated operation with rsp_ready high; checks handshake, latency and result.
  task automatic do_op(input string tag, input int id, input logic [3:0] a, input logic [3:0] b,
                       input logic m, input logic [3:0] exp_s, input logic exp_c,
                       input logic exp_v);
    @(negedge clk);
    drive_req(id, 1'b1, a, b, m);
    bus.rsp_ready = 1'b1;
    #1;
    check_eq({tag, ".ready"}, 32'(id == 0 ? bus.req0_ready : bus.req1_ready), 32'd1);
    @(negedge clk);
    drive_req(id, 1'b0, a, b, m);
    check_eq({tag, ".valid_e1"}, 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    check_eq({tag, ".valid_e2"}, 32'(bus.rsp_valid), 32'd1);
    check_eq({tag, ".s"}, 32'(bus.rsp_s), 32'(exp_s));
    check_eq({tag, ".cout"}, 32'(bus.rsp_cout), 32'(exp_c));
    check_eq({tag, ".v"}, 32'(bus.rsp_v), 32'(exp_v));
    check_eq({tag, ".id"}, 32'(bus.rsp_id), 32'(id));
  endtask

  logic [3:0] sat_pos;
  logic [3:0] sat_neg;

  initial begin
    n_total = 0;
    n_bad   = 0;
`ifdef ADDSUB_ARB_SAT_EN
    sat_pos = 4'b0111;
    sat_neg = 4'b1000;
`else
    sat_pos = 4'b1000;
    sat_neg = 4'b0111;
`endif
    rst_n = 1'b0;
    bus.rsp_ready = 1'b0;
    drive_req(0, 1'b1, 4'd0, 4'd0, 1'b0);
    drive_req(1, 1'b0, 4'd0, 4'd0, 1'b0);

    // Reset state; ready stays low while rst_n is low even with a valid request.
    repeat (2) @(negedge clk);
    check_eq("rst.ready0", 32'(bus.req0_ready), 32'd0);
    check_eq("rst.valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst.s", 32'(bus.rsp_s), 32'd0);
    check_eq("rst.id", 32'(bus.rsp_id), 32'd0);
    check_eq("rst.cout", 32'(bus.rsp_cout), 32'd0);
    check_eq("rst.v", 32'(bus.rsp_v), 32'd0);
    drive_req(0, 1'b0, 4'd0, 4'd0, 1'b0);
    rst_n = 1'b1;

    // Directed arithmetic vectors.
    do_op("add3p4", 0, 4'b0011, 4'b0100, 1'b0, 4'b0111, 1'b0, 1'b0);
    do_op("sub5m7", 1, 4'b0101, 4'b0111, 1'b1, 4'b1110, 1'b0, 1'b0);
    do_op("ovf7p1", 0, 4'b0111, 4'b0001, 1'b0, sat_pos, 1'b0, 1'b1);
    do_op("ovfm8m1", 1, 4'b1000, 4'b0001, 1'b1, sat_neg, 1'b1, 1'b1);
    do_op("wrapFp1", 0, 4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0);

    // Back-pressure in HOLD, then consume and accept req1 in the same cycle.
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    drive_req(0, 1'b1, 4'b0101, 4'b0011, 1'b1);
    #1;
    check_eq("hold.ready0", 32'(bus.req0_ready), 32'd1);
    @(negedge clk);
    drive_req(0, 1'b0, 4'd0, 4'd0, 1'b0);
    @(negedge clk);
    drive_req(1, 1'b1, 4'b1111, 4'b0001, 1'b0);
    #1;
    check_eq("hold.ready1_blk", 32'(bus.req1_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("hold.valid", 32'(bus.rsp_valid), 32'd1);
      check_eq("hold.s", 32'(bus.rsp_s), 32'd2);
      check_eq("hold.cout", 32'(bus.rsp_cout), 32'd1);
      check_eq("hold.id", 32'(bus.rsp_id), 32'd0);
      check_eq("hold.ready0", 32'(bus.req0_ready), 32'd0);
      check_eq("hold.ready1", 32'(bus.req1_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    #1;
    check_eq("hold.ready1_go", 32'(bus.req1_ready), 32'd1);
    @(negedge clk);
    drive_req(1, 1'b0, 4'd0, 4'd0, 1'b0);
    check_eq("hold.consumed", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    check_eq("hold.next_valid", 32'(bus.rsp_valid), 32'd1);
    check_eq("hold.next_s", 32'(bus.rsp_s), 32'd0);
    check_eq("hold.next_id", 32'(bus.rsp_id), 32'd1);

    // Abort a req0 operation in EXEC (last grant = 0 before reset).
    @(negedge clk);
    drive_req(0, 1'b1, 4'b0111, 4'b0001, 1'b0);
    #1;
    check_eq("abort.ready0", 32'(bus.req0_ready), 32'd1);
    @(negedge clk);
    drive_req(0, 1'b0, 4'd0, 4'd0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("abort.valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("abort.s", 32'(bus.rsp_s), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check_eq("abort.no_rsp", 32'(bus.rsp_valid), 32'd0);
    end

    // Continuous tie: grants alternate 0,1,0,1 starting with req0, one response per 2 cycles.
    drive_req(0, 1'b1, 4'b0001, 4'b0001, 1'b0);  // 1 + 1 = 2
    drive_req(1, 1'b1, 4'b0010, 4'b0001, 1'b1);  // 2 - 1 = 1
    bus.rsp_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      check_eq("tie.ready0", 32'(bus.req0_ready), 32'(k % 2 == 0));
      check_eq("tie.ready1", 32'(bus.req1_ready), 32'(k % 2 == 1));
      if (k > 0) begin
        check_eq("tie.rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check_eq("tie.rsp_id", 32'(bus.rsp_id), 32'((k - 1) % 2));
        check_eq("tie.rsp_s", 32'(bus.rsp_s), ((k - 1) % 2 == 0) ? 32'd2 : 32'd1);
      end
      @(negedge clk);
      check_eq("tie.gap", 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
    end
    check_eq("tie.last_valid", 32'(bus.rsp_valid), 32'd1);
    check_eq("tie.last_id", 32'(bus.rsp_id), 32'd1);
    check_eq("tie.last_s", 32'(bus.rsp_s), 32'd1);
    drive_req(0, 1'b0, 4'd0, 4'd0, 1'b0);
    drive_req(1, 1'b0, 4'd0, 4'd0, 1'b0);
    @(negedge clk);
    check_eq("end.idle", 32'(bus.rsp_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
